render_fetch_ctrl: RTL and testbench

RENDER_FETCH_CTRL -- requirements
Module: render_fetch_ctrl

---
 rtl/render_fetch_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_render_fetch_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_fetch_ctrl.sv
// Character-row fetch controller for the text renderer. For one pixel row it
// walks the character row buffer and, for each character, reads the glyph
// scanline and the background/foreground palette entries. Each character
// becomes one output record.
//
// Output handshake: a record transfers on a rising clk edge where out_valid
// and out_ready are both high; while out_valid is high and out_ready is low,
// out_valid and every record field hold their values.
module render_fetch_ctrl #(
   parameter int NUM_CHARS = 100
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        start,
   input  logic [3:0]  pixel_row,
   output logic        busy,
   output logic        done,
   output logic        chrowbuf_rd,
   output logic [7:0]  chrowbuf_rd_addr,
   input  logic [15:0] chrowbuf_rd_data,
   output logic        fontmem_rd,
   output logic [11:0] fontmem_rd_addr,
   input  logic [7:0]  fontmem_rd_data,
   output logic        palette_rd,
   output logic [7:0]  palette_rd_addr,
   input  logic [15:0] palette_rd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_pattern,
   output logic [15:0] out_bg,
   output logic [15:0] out_fg,
   output logic        out_last,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHAR  = 3'd1,
      S_FONT  = 3'd2,
      S_FG    = 3'd3,
      S_STAGE = 3'd4,
      S_HOLD  = 3'd5,
      S_DRAIN = 3'd6
   } state_e;

   localparam logic [7:0] LAST_IDX = 8'(NUM_CHARS - 1);

   state_e      state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [3:0]  row_q, row_d;
   logic [7:0]  attr_q, attr_d;
   logic [7:0]  pattern_q, pattern_d;
   logic [15:0] bg_q, bg_d;
   logic [15:0] fg_q, fg_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic [7:0]  out_pattern_q, out_pattern_d;
   logic [15:0] out_bg_q, out_bg_d;
   logic [15:0] out_fg_q, out_fg_d;
   logic        done_q, done_d;

   logic        slot_free;
   logic        load;
   logic [15:0] load_fg;

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         row_q         <= '0;
         attr_q        <= '0;
         pattern_q     <= '0;
         bg_q          <= '0;
         fg_q          <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         out_pattern_q <= '0;
         out_bg_q      <= '0;
         out_fg_q      <= '0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         row_q         <= row_d;
         attr_q        <= attr_d;
         pattern_q     <= pattern_d;
         bg_q          <= bg_d;
         fg_q          <= fg_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
         out_pattern_q <= out_pattern_d;
         out_bg_q      <= out_bg_d;
         out_fg_q      <= out_fg_d;
         done_q        <= done_d;
      end
   end

   // Next-state, capture and output-record load logic
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      row_d         = row_q;
      attr_d        = attr_q;
      pattern_d     = pattern_q;
      bg_d          = bg_q;
      fg_d          = fg_q;
      out_last_d    = out_last_q;
      out_pattern_d = out_pattern_q;
      out_bg_d      = out_bg_q;
      out_fg_d      = out_fg_q;
      done_d        = 1'b0;
      // A presented record retires on acceptance unless replaced below.
      out_valid_d   = out_valid_q & ~out_ready;
      slot_free     = ~out_valid_q | out_ready;
      load          = 1'b0;
      load_fg       = fg_q;

      case (state_q)
         S_IDLE: begin
            // done_q blocks a start that arrives in the done cycle.
            if (start && !done_q) begin
               state_d = S_CHAR;
               idx_d   = '0;
               row_d   = pixel_row;
            end
         end
         S_CHAR: state_d = S_FONT;
         S_FONT: begin
            attr_d  = chrowbuf_rd_data[15:8];
            state_d = S_FG;
         end
         S_FG: begin
            pattern_d = fontmem_rd_data;
            bg_d      = palette_rd_data;
            state_d   = S_STAGE;
         end
         S_STAGE: begin
            fg_d = palette_rd_data;
            if (slot_free) begin
               load    = 1'b1;
               load_fg = palette_rd_data;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (slot_free) load = 1'b1;
         end
         S_DRAIN: begin
            if (out_valid_q && out_ready) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         out_valid_d   = 1'b1;
         out_pattern_d = pattern_q;
         out_bg_d      = bg_q;
         out_fg_d      = load_fg;
         out_last_d    = (idx_q == LAST_IDX);
         if (idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
         end else begin
            state_d = S_CHAR;
            idx_d   = idx_q + 8'd1;
         end
      end
   end

   // Memory strobes and addresses decoded from the current state; the font
   // and bg palette addresses in FONT come straight from the buffer read data.
   always_comb begin
      chrowbuf_rd      = 1'b1;
      chrowbuf_rd_addr = '0;
      fontmem_rd       = 1'b1;
      fontmem_rd_addr  = '0;
      palette_rd       = 1'b1;
      palette_rd_addr  = '0;
      case (state_q)
         S_CHAR: begin
            chrowbuf_rd      = 1'b0;
            chrowbuf_rd_addr = idx_q;
         end
         S_FONT: begin
            fontmem_rd      = 1'b0;
            fontmem_rd_addr = {chrowbuf_rd_data[7:0], row_q};
            palette_rd      = 1'b0;
            palette_rd_addr = {4'h0, chrowbuf_rd_data[11:8]};
         end
         S_FG: begin
            palette_rd      = 1'b0;
            palette_rd_addr = {4'h0, attr_q[7:4]};
         end
         default: ;
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign out_pattern = out_pattern_q;
   assign out_bg      = out_bg_q;
   assign out_fg      = out_fg_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_render_fetch_ctrl.sv
// Bench for render_fetch_ctrl: a NUM_CHARS=4 instance exercised with several
// rows and a NUM_CHARS=1 instance for the single-character row.
module tb_render_fetch_ctrl;
   localparam int N  = 4;
   localparam int RW = 41;  // {last, pattern, bg, fg}
   localparam logic [74:0] RST_VEC = {4'b0000, 8'h00, 16'h0000, 16'h0000, 3'b111, 8'h00, 12'h000, 8'h00};

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic nrst = 1'b0;

   logic        start = 1'b0, start1 = 1'b0;
   logic [3:0]  pixel_row = 4'h0;
   logic        out_ready = 1'b1, out_ready1 = 1'b1;

   logic        busy, done, crb_rd, font_rd, pal_rd, out_valid, out_last;
   logic [7:0]  crb_addr, pal_addr, out_pattern, font_data;
   logic [11:0] font_addr;
   logic [15:0] crb_data, pal_data, out_bg, out_fg;
   logic [2:0]  dbg_state;

   logic        busy1, done1, crb_rd1, font_rd1, pal_rd1, out_valid1, out_last1;
   logic [7:0]  crb_addr1, pal_addr1, out_pattern1, font_data1;
   logic [11:0] font_addr1;
   logic [15:0] crb_data1, pal_data1, out_bg1, out_fg1;
   logic [2:0]  dbg_state1;

   render_fetch_ctrl #(.NUM_CHARS(N)) u_dut (
      .clk(clk), .nrst(nrst), .start(start), .pixel_row(pixel_row),
      .busy(busy), .done(done),
      .chrowbuf_rd(crb_rd), .chrowbuf_rd_addr(crb_addr), .chrowbuf_rd_data(crb_data),
      .fontmem_rd(font_rd), .fontmem_rd_addr(font_addr), .fontmem_rd_data(font_data),
      .palette_rd(pal_rd), .palette_rd_addr(pal_addr), .palette_rd_data(pal_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pattern(out_pattern),
      .out_bg(out_bg), .out_fg(out_fg), .out_last(out_last), .dbg_state(dbg_state)
   );

   render_fetch_ctrl #(.NUM_CHARS(1)) u_dut1 (
      .clk(clk), .nrst(nrst), .start(start1), .pixel_row(pixel_row),
      .busy(busy1), .done(done1),
      .chrowbuf_rd(crb_rd1), .chrowbuf_rd_addr(crb_addr1), .chrowbuf_rd_data(crb_data1),
      .fontmem_rd(font_rd1), .fontmem_rd_addr(font_addr1), .fontmem_rd_data(font_data1),
      .palette_rd(pal_rd1), .palette_rd_addr(pal_addr1), .palette_rd_data(pal_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_pattern(out_pattern1),
      .out_bg(out_bg1), .out_fg(out_fg1), .out_last(out_last1), .dbg_state(dbg_state1)
   );

   // memory contents and one-cycle-latency read models
   logic [15:0] crb_mem [256];
   logic [7:0]  font_mem [4096];
   logic [15:0] pal_mem [256];

   always @(posedge clk) begin
      if (crb_rd === 1'b0)   crb_data   <= crb_mem[crb_addr];
      if (font_rd === 1'b0)  font_data  <= font_mem[font_addr];
      if (pal_rd === 1'b0)   pal_data   <= pal_mem[pal_addr];
      if (crb_rd1 === 1'b0)  crb_data1  <= crb_mem[crb_addr1];
      if (font_rd1 === 1'b0) font_data1 <= font_mem[font_addr1];
      if (pal_rd1 === 1'b0)  pal_data1  <= pal_mem[pal_addr1];
   end

   int tests = 0;
   int fails = 0;

   // scoreboard
   logic [RW-1:0] exp_q[$];
   logic [7:0]    ca_q[$];
   logic [11:0]   fa_q[$];
   logic [7:0]    pa_q[$];
   logic [RW-1:0] cur_rec, cur_rec1, held_rec, mon_exp;
   bit            held = 1'b0;

   assign cur_rec  = {out_last, out_pattern, out_bg, out_fg};
   assign cur_rec1 = {out_last1, out_pattern1, out_bg1, out_fg1};

   // Reference record for character k of an n-character row.
   function automatic logic [RW-1:0] make_rec(input int k, input int n, input logic [3:0] row);
      logic [15:0] entry;
      logic [7:0]  attr, code;
      logic        last;
      entry = crb_mem[k];
      attr  = entry[15:8];
      code  = entry[7:0];
      last  = (k == n - 1);
      return {last, font_mem[{code, row}], pal_mem[{4'h0, attr[3:0]}], pal_mem[{4'h0, attr[7:4]}]};
   endfunction

   function automatic logic [74:0] dut_vec();
      return {busy, done, out_valid, out_last, out_pattern, out_bg, out_fg,
              crb_rd, font_rd, pal_rd, crb_addr, font_addr, pal_addr};
   endfunction

   always @(negedge clk) begin
      if (!nrst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            tests++;
            if (out_valid !== 1'b1 || cur_rec !== held_rec) begin
               fails++;
               $display("FAIL hold_stable: valid=%b rec=%h required valid=1 rec=%h", out_valid, cur_rec, held_rec);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_record: rec=%h required none", cur_rec);
            end else begin
               mon_exp = exp_q.pop_front();
               if (cur_rec !== mon_exp) begin
                  fails++;
                  $display("FAIL record: got %h required %h", cur_rec, mon_exp);
               end
            end
         end
         if (busy === 1'b0) begin
            tests++;
            if ({crb_rd, font_rd, pal_rd} !== 3'b111) begin
               fails++;
               $display("FAIL idle_strobe: strobes=%b required 111", {crb_rd, font_rd, pal_rd});
            end
         end
         held     = (out_valid === 1'b1) && (out_ready === 1'b0);
         held_rec = cur_rec;
         if (crb_rd === 1'b0)  ca_q.push_back(crb_addr);
         if (font_rd === 1'b0) fa_q.push_back(font_addr);
         if (pal_rd === 1'b0)  pa_q.push_back(pal_addr);
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem(input int mode);
      for (int i = 0; i < 256; i++) begin
         case (mode)
            1:       crb_mem[i] = {8'h21, 8'(i)};
            2:       crb_mem[i] = 16'hFFFF;
            default: crb_mem[i] = 16'($urandom);
         endcase
         pal_mem[i] = 16'($urandom);
      end
      for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
   endtask

   // Runs one full row on the 4-character instance and checks its timing,
   // memory address sequence and done pulse; ends in the done cycle.
   task automatic run_row(input logic [3:0] row, input bit rnd_ready, input bit poke_start);
      int cyc, acc_cyc, done_cyc, bad_k;
      int rises[$];
      logic prev_v;
      bit acc_now, ok;
      logic [15:0] e;
      ca_q.delete(); fa_q.delete(); pa_q.delete();
      for (int k = 0; k < N; k++) exp_q.push_back(make_rec(k, N, row));
      pixel_row = row;
      start     = 1'b1;
      out_ready = 1'b1;
      tick();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL start_accept: busy=%b required 1", busy);
      end
      start     = 1'b0;
      pixel_row = 4'($urandom);
      cyc = 0; acc_cyc = -1; done_cyc = -1; prev_v = 1'b0;
      while (done_cyc < 0 && cyc < 400) begin
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke_start) start = 1'($urandom_range(0, 1));
         acc_now = (out_valid === 1'b1) && out_ready && (out_last === 1'b1);
         tick();
         cyc++;
         if (acc_now) acc_cyc = cyc;
         if (out_valid === 1'b1 && !prev_v) rises.push_back(cyc);
         prev_v = out_valid;
         if (done === 1'b1) done_cyc = cyc;
      end
      start = 1'b0;
      tests++;
      if (done_cyc < 0) begin
         fails++;
         $display("FAIL done_timeout: no done within %0d cycles", cyc);
      end
      tests++;
      if (done_cyc != acc_cyc) begin
         fails++;
         $display("FAIL done_timing: done at cycle %0d required %0d", done_cyc, acc_cyc);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL busy_at_done: busy=%b required 0", busy);
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL records_left: %0d required 0", exp_q.size());
      end
      tests++;
      ok = (ca_q.size() == N) && (fa_q.size() == N) && (pa_q.size() == 2 * N);
      if (!ok) begin
         fails++;
         $display("FAIL addr_count: chrowbuf=%0d font=%0d pal=%0d required %0d %0d %0d",
                  ca_q.size(), fa_q.size(), pa_q.size(), N, N, 2 * N);
      end else begin
         bad_k = -1;
         for (int k = 0; k < N; k++) begin
            e = crb_mem[k];
            if (bad_k < 0 && (ca_q[k] !== 8'(k) || fa_q[k] !== {e[7:0], row} ||
                pa_q[2*k] !== {4'h0, e[11:8]} || pa_q[2*k+1] !== {4'h0, e[15:12]})) bad_k = k;
         end
         if (bad_k >= 0) begin
            e = crb_mem[bad_k];
            fails++;
            $display("FAIL addr_seq char %0d: got chrowbuf %h font %h pal %h %h required %h %h %h %h",
                     bad_k, ca_q[bad_k], fa_q[bad_k], pa_q[2*bad_k], pa_q[2*bad_k+1],
                     8'(bad_k), {e[7:0], row}, {4'h0, e[11:8]}, {4'h0, e[15:12]});
         end
      end
      if (!rnd_ready) begin
         tests++;
         ok = (rises.size() == N);
         for (int k = 0; k < N && ok; k++) if (rises[k] != 4 * (k + 1)) ok = 1'b0;
         if (!ok) begin
            fails++;
            $display("FAIL record_cadence: %0d loads first at %0d required %0d loads at 4,8,..",
                     rises.size(), (rises.size() > 0) ? rises[0] : -1, N);
         end
      end
   endtask

   // test tasks
   task automatic test_reset();
      nrst = 1'b0;
      tick();
      tick();
      tests++;
      if (dut_vec() !== RST_VEC) begin
         fails++;
         $display("FAIL reset_state: got %h required %h", dut_vec(), RST_VEC);
      end
      tests++;
      if ({busy1, done1, out_valid1, crb_rd1, font_rd1, pal_rd1} !== 6'b000111) begin
         fails++;
         $display("FAIL reset_state_n1: got %b required 000111", {busy1, done1, out_valid1, crb_rd1, font_rd1, pal_rd1});
      end
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_main();
      fill_mem(1);
      run_row(4'd5, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_boundary();
      fill_mem(2);
      run_row(4'd15, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_backpressure();
      int cyc;
      bit strobe_bad;
      fill_mem(0);
      for (int k = 0; k < N; k++) exp_q.push_back(make_rec(k, N, 4'd9));
      pixel_row = 4'd9;
      out_ready = 1'b0;
      start     = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      tests++;
      if (cyc != 4) begin
         fails++;
         $display("FAIL bp_latency: out_valid after %0d cycles required 4", cyc);
      end
      repeat (4) tick();
      strobe_bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if ({crb_rd, font_rd, pal_rd} !== 3'b111 || busy !== 1'b1) strobe_bad = 1'b1;
         tick();
      end
      tests++;
      if (strobe_bad) begin
         fails++;
         $display("FAIL hold_strobes: strobe seen or busy low while held, required strobes 111 busy 1");
      end
      out_ready = 1'b1;
      tick();
      tests++;
      if (exp_q.size() == 0 || out_valid !== 1'b1 || cur_rec !== exp_q[0]) begin
         fails++;
         $display("FAIL bp_release: valid=%b rec=%h required valid=1 rec=%h",
                  out_valid, cur_rec, (exp_q.size() > 0) ? exp_q[0] : '0);
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
      tests++;
      if (done !== 1'b1 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL bp_finish: done=%b left=%0d required done=1 left=0", done, exp_q.size());
      end
      tick();
   endtask

   task automatic test_start_ignored();
      fill_mem(0);
      run_row(4'($urandom), 1'b1, 1'b1);
      start = 1'b1;  // in the done cycle
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL start_in_done: busy=%b done=%b required 0 0", busy, done);
      end
      run_row(4'($urandom), 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         fill_mem(0);
         run_row(4'($urandom), 1'b1, 1'b0);
         repeat ($urandom_range(1, 3)) tick();
      end
   endtask

   task automatic test_single_char();
      logic [RW-1:0] e;
      logic [3:0] row;
      int cyc;
      fill_mem(0);
      row = 4'($urandom);
      pixel_row  = row;
      e          = make_rec(0, 1, row);
      out_ready1 = 1'b0;
      start1     = 1'b1;
      tick();
      start1 = 1'b0;
      cyc = 0;
      while (out_valid1 !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      tests++;
      if (cyc != 4) begin
         fails++;
         $display("FAIL n1_latency: out_valid after %0d cycles required 4", cyc);
      end
      repeat (2) tick();
      tests++;
      if (cur_rec1 !== e || done1 !== 1'b0 || busy1 !== 1'b1) begin
         fails++;
         $display("FAIL n1_record: rec=%h done=%b busy=%b required rec=%h done=0 busy=1", cur_rec1, done1, busy1, e);
      end
      out_ready1 = 1'b1;
      tick();
      tests++;
      if ({done1, busy1, out_valid1} !== 3'b100) begin
         fails++;
         $display("FAIL n1_done: done/busy/valid=%b required 100", {done1, busy1, out_valid1});
      end
      tick();
      tests++;
      if ({done1, busy1} !== 2'b00) begin
         fails++;
         $display("FAIL n1_after: done/busy=%b required 00", {done1, busy1});
      end
   endtask

   task automatic test_reset_mid_row();
      bit bad;
      fill_mem(0);
      for (int k = 0; k < N; k++) exp_q.push_back(make_rec(k, N, 4'd3));
      pixel_row = 4'd3;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      nrst = 1'b0;
      tick();
      tests++;
      if (dut_vec() !== RST_VEC) begin
         fails++;
         $display("FAIL mid_reset_1: got %h required %h", dut_vec(), RST_VEC);
      end
      tick();
      tests++;
      if (dut_vec() !== RST_VEC) begin
         fails++;
         $display("FAIL mid_reset_2: got %h required %h", dut_vec(), RST_VEC);
      end
      nrst = 1'b1;
      exp_q.delete();
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL abort_quiet: done/busy/valid rose after aborted row, required 0");
      end
   endtask

   initial begin
      fill_mem(0);
      test_reset();
      test_main();
      test_boundary();
      test_backpressure();
      test_start_ignored();
      test_random();
      test_single_char();
      test_reset_mid_row();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
